// File: rtl/gpr_wb_arb_pkg.sv
// Shared constants and types for the GPR writeback arbiter.
// Carries the cpu.h defines used by the writer side of the register file.
package gpr_wb_arb_pkg;

    localparam int unsigned WB_QDEPTH     = 2;
    localparam int unsigned WB_STARVE_MAX = 4;
    localparam int unsigned REG_ADDR_W    = 5;
    localparam int unsigned WORD_DATA_W   = 32;
    localparam int unsigned REG_NUM       = 32;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef enum logic [1:0] {
        SRC_IDLE,
        SRC_PIPE,
        SRC_QUEUE,
        SRC_BYPASS
    } wb_src_e;

endpackage

// File: rtl/gpr_wb_fifo.sv
// Small synchronous FIFO holding {addr, data} multi-cycle results.
// Push is ignored when full and pop is ignored when empty.
module gpr_wb_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 37
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/gpr_wb_arb.sv
// Owns the GPR write port: merges pipeline writeback with queued or bypassed
// multi-cycle results, and tracks pending multi-cycle destinations.
module gpr_wb_arb
    import gpr_wb_arb_pkg::*;
#(
    parameter int unsigned DATA_W     = WORD_DATA_W,
    parameter int unsigned ADDR_W     = REG_ADDR_W,
    parameter int unsigned REG_NUM    = gpr_wb_arb_pkg::REG_NUM,
    parameter int unsigned QDEPTH     = WB_QDEPTH,
    parameter int unsigned STARVE_MAX = WB_STARVE_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_we_,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_data,
    output logic              pipe_stall,
    input  logic              mc_issue,
    input  logic [ADDR_W-1:0] mc_issue_addr,
    input  logic              mc_valid,
    input  logic [ADDR_W-1:0] mc_addr,
    input  logic [DATA_W-1:0] mc_data,
    output logic              mc_ready,
    input  logic [ADDR_W-1:0] chk_addr_0,
    input  logic [ADDR_W-1:0] chk_addr_1,
    output logic              busy_0,
    output logic              busy_1,
    output logic              we_,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    wb_src_e                  src;
    logic                     q_push;
    logic                     q_pop;
    logic                     q_full;
    logic                     q_empty;
    logic [ADDR_W+DATA_W-1:0] q_head;
    logic [ADDR_W-1:0]        head_addr;
    logic [DATA_W-1:0]        head_data;
    logic [CNT_W-1:0]         starve_cnt;
    logic [REG_NUM-1:0]       busy;
    logic [REG_NUM-1:0]       busy_nxt;

    assign head_addr  = q_head[ADDR_W+DATA_W-1:DATA_W];
    assign head_data  = q_head[DATA_W-1:0];
    assign mc_ready   = !q_full;
    assign pipe_stall = (starve_cnt == CNT_W'(STARVE_MAX)) && !q_empty;
    assign busy_0     = busy[chk_addr_0];
    assign busy_1     = busy[chk_addr_1];

    always_comb begin
        src = SRC_IDLE;
        if (pipe_stall)      src = SRC_QUEUE;
        else if (!pipe_we_)  src = SRC_PIPE;
        else if (!q_empty)   src = SRC_QUEUE;
        else if (mc_valid)   src = SRC_BYPASS;
    end

    assign q_pop  = (src == SRC_QUEUE);
    assign q_push = mc_valid && mc_ready && (src != SRC_BYPASS);

    gpr_wb_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (q_push),
        .pop   (q_pop),
        .din   ({mc_addr, mc_data}),
        .head  (q_head),
        .full  (q_full),
        .empty (q_empty)
    );

    // Clear first, then set: a new issue to the retiring register stays busy.
    always_comb begin
        busy_nxt = busy;
        if (src == SRC_QUEUE)  busy_nxt[head_addr] = 1'b0;
        if (src == SRC_BYPASS) busy_nxt[mc_addr]   = 1'b0;
        if (mc_issue)          busy_nxt[mc_issue_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
            busy       <= '0;
        end else begin
            busy <= busy_nxt;
            if (q_pop)
                starve_cnt <= '0;
            else if (q_full && (starve_cnt != CNT_W'(STARVE_MAX)))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_     <= DISABLE_;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            we_ <= DISABLE_;
            unique case (src)
                SRC_PIPE: begin
                    we_     <= ENABLE_;
                    wr_addr <= pipe_addr;
                    wr_data <= pipe_data;
                end
                SRC_QUEUE: begin
                    we_     <= ENABLE_;
                    wr_addr <= head_addr;
                    wr_data <= head_data;
                end
                SRC_BYPASS: begin
                    we_     <= ENABLE_;
                    wr_addr <= mc_addr;
                    wr_data <= mc_data;
                end
                default: ;
            endcase
        end
    end

endmodule
